// File: rtl/exc_commit_pkg.sv
// Shared exception codes, interface widths, FSM/select enums and the interrupt-pending helper
// for the MEM-stage exception committer.
package exc_commit_pkg;

    localparam int EXC_CODE_W  = 5;
    localparam int CP0_INT_W   = 6;
    localparam int INST_ADDR_W = 32;
    localparam int REG_W       = 32;

    localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'h00;
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'h05;
    localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXC_CODE_W-1:0] EXC_BP   = 5'h09;
    localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'h0c;
    localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'h10;
    localparam logic [EXC_CODE_W-1:0] EXC_ERET = 5'h11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SQUASH = 2'd2
    } exc_state_e;

    // Which address (if any) is latched as the faulting virtual address
    typedef enum logic [1:0] {
        BV_HOLD = 2'd0,
        BV_PC   = 2'd1,
        BV_ADDR = 2'd2
    } bv_sel_e;

    function automatic logic int_pending(input logic ie, input logic exl,
                                         input logic [7:0] ip, input logic [7:0] im);
        return ie & ~exl & (|(ip & im));
    endfunction

endpackage

// File: rtl/exc_commit_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines; all stages reset to 0.
module exc_commit_int_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    // Shift each line through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/exc_commit.sv
// MEM-stage exception committer: prioritises exception/interrupt sources and hands a registered
// exccode/pc/in_delay to cp0, then squashes wrong-path work. Optional badvaddr_o via EXC_BADVADDR_EN.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SQUASH_CYC  = 1
) (
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst_n,
    input  logic [CP0_INT_W-1:0]   hw_int_i,
    input  logic                   mem_valid_i,
    input  logic [INST_ADDR_W-1:0] mem_pc_i,
    input  logic                   mem_in_delay_i,
    input  logic                   if_adel_i,
    input  logic                   id_ri_i,
    input  logic                   id_sys_i,
    input  logic                   id_bp_i,
    input  logic                   id_eret_i,
    input  logic                   exe_ov_i,
    input  logic                   mem_adel_i,
    input  logic                   mem_ades_i,
    input  logic [REG_W-1:0]       mem_addr_i,
    input  logic [REG_W-1:0]       status_i,
    input  logic [REG_W-1:0]       cause_i,
    output logic [CP0_INT_W-1:0]   int_o,
    output logic [EXC_CODE_W-1:0]  exccode_o,
    output logic [INST_ADDR_W-1:0] exc_pc_o,
    output logic                   in_delay_o,
`ifdef EXC_BADVADDR_EN
    output logic [REG_W-1:0]       badvaddr_o,
`endif
    output logic                   mem_kill_o
);

    localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYC);

    exc_state_e             state_r;
    exc_state_e             state_nxt_s;
    logic [2:0]             cnt_r;
    logic [2:0]             cnt_nxt_s;
    logic                   int_pend_s;
    logic [EXC_CODE_W-1:0]  cand_s;
    bv_sel_e                bv_sel_s;
    logic [EXC_CODE_W-1:0]  exccode_r;
    logic [INST_ADDR_W-1:0] exc_pc_r;
    logic                   in_delay_r;

    exc_commit_int_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (CP0_INT_W)
    ) u_int_sync (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .d     (hw_int_i),
        .q     (int_o)
    );

    assign int_pend_s = int_pending(status_i[0], status_i[1],
                                    {cause_i[15:10], cause_i[9:8]}, status_i[15:8]);

    // Priority encoder: only an IDLE FSM with a real MEM instruction may raise a candidate
    always_comb begin
        cand_s   = EXC_NONE;
        bv_sel_s = BV_HOLD;
        if ((state_r == ST_IDLE) && mem_valid_i) begin
            if (int_pend_s) begin
                cand_s = EXC_INT;
            end else if (if_adel_i) begin
                cand_s   = EXC_ADEL;
                bv_sel_s = BV_PC;
            end else if (id_ri_i) begin
                cand_s = EXC_RI;
            end else if (exe_ov_i) begin
                cand_s = EXC_OV;
            end else if (id_sys_i) begin
                cand_s = EXC_SYS;
            end else if (id_bp_i) begin
                cand_s = EXC_BP;
            end else if (mem_adel_i) begin
                cand_s   = EXC_ADEL;
                bv_sel_s = BV_ADDR;
            end else if (mem_ades_i) begin
                cand_s   = EXC_ADES;
                bv_sel_s = BV_ADDR;
            end else if (id_eret_i) begin
                cand_s = EXC_ERET;
            end else begin
                cand_s = EXC_NONE;
            end
        end else begin
            cand_s = EXC_NONE;
        end
    end

    // Next-state logic: COMMIT lasts one cycle while cp0 flushes, SQUASH counts down
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_s != EXC_NONE) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_SQUASH;
                cnt_nxt_s   = SQUASH_INIT;
            end
            ST_SQUASH: begin
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_SQUASH;
                    cnt_nxt_s   = cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State and squash counter registers
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered cp0 handoff: exccode is a one-cycle pulse, pc/in_delay hold the last commit
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            exccode_r  <= EXC_NONE;
            exc_pc_r   <= 32'h0000_0000;
            in_delay_r <= 1'b0;
        end else begin
            exccode_r <= cand_s;
            if (cand_s != EXC_NONE) begin
                exc_pc_r   <= mem_pc_i;
                in_delay_r <= mem_in_delay_i;
            end
        end
    end

    assign exccode_o  = exccode_r;
    assign exc_pc_o   = exc_pc_r;
    assign in_delay_o = in_delay_r;
    assign mem_kill_o = (cand_s != EXC_NONE) || (state_r == ST_COMMIT) || (state_r == ST_SQUASH);

`ifdef EXC_BADVADDR_EN
    logic [REG_W-1:0] badvaddr_r;

    // Faulting address captured alongside the exception code
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            badvaddr_r <= 32'h0000_0000;
        end else begin
            case (bv_sel_s)
                BV_PC:   badvaddr_r <= mem_pc_i;
                BV_ADDR: badvaddr_r <= mem_addr_i;
                default: badvaddr_r <= badvaddr_r;
            endcase
        end
    end

    assign badvaddr_o = badvaddr_r;

    logic unused_s;
    assign unused_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
    logic unused_s;
    assign unused_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0],
                        mem_addr_i, bv_sel_s};
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench for exc_commit: table of single-instruction vectors plus directed
// sequences for squash, interrupt synchronisation, EXL masking and reset during SQUASH.
module tb_exc_commit;

    logic        clk;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic        valid;
    logic [31:0] pc;
    logic        dly;
    logic        if_adel, id_ri, id_sys, id_bp, id_eret, exe_ov, mem_adel, mem_ades;
    logic [31:0] addr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [5:0]  int_o;
    logic [4:0]  exccode_o;
    logic [31:0] exc_pc_o;
    logic        in_delay_o;
    logic        mem_kill_o;
`ifdef EXC_BADVADDR_EN
    logic [31:0] badvaddr_o;
`endif

    int errors = 0;
    int checks = 0;

    exc_commit dut (
        .cpu_clk_50M    (clk),
        .cpu_rst_n      (rst_n),
        .hw_int_i       (hw_int),
        .mem_valid_i    (valid),
        .mem_pc_i       (pc),
        .mem_in_delay_i (dly),
        .if_adel_i      (if_adel),
        .id_ri_i        (id_ri),
        .id_sys_i       (id_sys),
        .id_bp_i        (id_bp),
        .id_eret_i      (id_eret),
        .exe_ov_i       (exe_ov),
        .mem_adel_i     (mem_adel),
        .mem_ades_i     (mem_ades),
        .mem_addr_i     (addr),
        .status_i       (status),
        .cause_i        (cause),
        .int_o          (int_o),
        .exccode_o      (exccode_o),
        .exc_pc_o       (exc_pc_o),
        .in_delay_o     (in_delay_o),
`ifdef EXC_BADVADDR_EN
        .badvaddr_o     (badvaddr_o),
`endif
        .mem_kill_o     (mem_kill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags: {if_adel, id_ri, exe_ov, id_sys, id_bp, mem_adel, mem_ades, id_eret}
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        dly;
        logic [7:0]  flags;
        logic [31:0] addr;
        logic [31:0] status;
        logic [31:0] cause;
        logic [4:0]  exp_code;
        logic [1:0]  bv_sel;   // 0 hold, 1 pc, 2 addr
    } vec_t;

    vec_t vecs[$];

    logic [31:0] exp_pc = 32'h0;
    logic        exp_dly = 1'b0;
    logic [31:0] exp_bv = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic d, input logic [7:0] f,
                         input logic [31:0] a, input logic [31:0] st, input logic [31:0] ca);
        valid = v; pc = p; dly = d; addr = a; status = st; cause = ca;
        {if_adel, id_ri, exe_ov, id_sys, id_bp, mem_adel, mem_ades, id_eret} = f;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".exccode"}, {27'h0, exccode_o}, {27'h0, 5'h10});
        check({tag, ".exc_pc"}, exc_pc_o, exp_pc);
        check({tag, ".in_delay"}, {31'h0, in_delay_o}, {31'h0, exp_dly});
`ifdef EXC_BADVADDR_EN
        check({tag, ".badvaddr"}, badvaddr_o, exp_bv);
`endif
    endtask

    initial begin
        hw_int = 6'h00;
        drive_idle();
        rst_n = 1'b0;

        // Test 1: reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset.int_o", {26'h0, int_o}, 32'h0);
        check("reset.kill", {31'h0, mem_kill_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{1'b1, 32'hBFC0_0100, 1'b0, 8'b0110_0000, 32'h0, 32'h0, 32'h0, 5'h0a, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0104, 1'b1, 8'b1100_0000, 32'h0, 32'h0, 32'h0, 5'h04, 2'd1});
        vecs.push_back('{1'b1, 32'hBFC0_0108, 1'b0, 8'b0011_0000, 32'h0, 32'h0, 32'h0, 5'h0c, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_010C, 1'b0, 8'b0001_1000, 32'h0, 32'h0, 32'h0, 5'h08, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0110, 1'b1, 8'b0000_1100, 32'h1234_5678, 32'h0, 32'h0, 5'h09, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0114, 1'b0, 8'b0000_0110, 32'h8000_0003, 32'h0, 32'h0, 5'h04, 2'd2});
        vecs.push_back('{1'b1, 32'hBFC0_0118, 1'b0, 8'b0000_0011, 32'h8000_0102, 32'h0, 32'h0, 5'h05, 2'd2});
        vecs.push_back('{1'b1, 32'hBFC0_011C, 1'b1, 8'b0000_0001, 32'h0, 32'h0, 32'h0, 5'h11, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0120, 1'b0, 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'h10, 2'd0});
        vecs.push_back('{1'b0, 32'hBFC0_0124, 1'b1, 8'b0100_0000, 32'h0, 32'h0, 32'h0, 5'h10, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0128, 1'b0, 8'b1100_0000, 32'h0, 32'h0000_0101, 32'h0000_0100, 5'h00, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_012C, 1'b1, 8'b0100_0000, 32'h0, 32'h0000_0103, 32'h0000_0100, 5'h0a, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0130, 1'b0, 8'b0000_0000, 32'h0, 32'h0000_0201, 32'h0000_0100, 5'h10, 2'd0});
        vecs.push_back('{1'b1, 32'hBFC0_0134, 1'b0, 8'b0000_0000, 32'h0, 32'h0000_0200, 32'h0000_0200, 5'h10, 2'd0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].pc, vecs[i].dly, vecs[i].flags, vecs[i].addr,
                  vecs[i].status, vecs[i].cause);
            #1;
            check($sformatf("vec%0d.kill", i), {31'h0, mem_kill_o},
                  {31'h0, (vecs[i].exp_code != 5'h10)});
            @(posedge clk);
            #1;
            if (vecs[i].exp_code != 5'h10) begin
                exp_pc  = vecs[i].pc;
                exp_dly = vecs[i].dly;
            end
            if (vecs[i].bv_sel == 2'd1) exp_bv = vecs[i].pc;
            else if (vecs[i].bv_sel == 2'd2) exp_bv = vecs[i].addr;
            check($sformatf("vec%0d.exccode", i), {27'h0, exccode_o}, {27'h0, vecs[i].exp_code});
            check($sformatf("vec%0d.exc_pc", i), exc_pc_o, exp_pc);
            check($sformatf("vec%0d.in_delay", i), {31'h0, in_delay_o}, {31'h0, exp_dly});
`ifdef EXC_BADVADDR_EN
            check($sformatf("vec%0d.badvaddr", i), badvaddr_o, exp_bv);
`endif
            drive_idle();
            repeat (3) @(posedge clk);
        end

        // Test 2: RI beats OV, then COMMIT and SQUASH ignore a following syscall
        @(negedge clk);
        drive(1'b1, 32'hBFC0_0100, 1'b0, 8'b0110_0000, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("sq.exccode0", {27'h0, exccode_o}, {27'h0, 5'h0a});
        check("sq.exc_pc", exc_pc_o, 32'hBFC0_0100);
        drive(1'b1, 32'hBFC0_0104, 1'b1, 8'b0001_0000, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("sq.kill%0d", c), {31'h0, mem_kill_o}, 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("sq.exccode%0d", c + 1), {27'h0, exccode_o}, {27'h0, 5'h10});
        end
        @(posedge clk);
        #1;
        check("sq.resume", {27'h0, exccode_o}, {27'h0, 5'h08});
        check("sq.resume_dly", {31'h0, in_delay_o}, 32'h1);
        drive_idle();
        repeat (3) @(posedge clk);

        // Test 3: hw_int[2] through the synchroniser, then taken as an interrupt
        @(negedge clk);
        hw_int = 6'b000100;
        @(posedge clk);
        #1;
        check("int.sync1", {26'h0, int_o}, 32'h0);
        @(posedge clk);
        #1;
        check("int.sync2", {26'h0, int_o}, 32'h0000_0004);
        drive(1'b1, 32'h0000_0200, 1'b0, 8'h00, 32'h0, 32'h0000_1001, 32'h0000_1000);
        @(posedge clk);
        #1;
        check("int.exccode", {27'h0, exccode_o}, {27'h0, 5'h00});
        check("int.exc_pc", exc_pc_o, 32'h0000_0200);
        drive_idle();
        repeat (3) @(posedge clk);

        // Test 4: EXL masks the interrupt; ADES in a delay slot
        @(negedge clk);
        drive(1'b1, 32'h0000_0204, 1'b0, 8'h00, 32'h0, 32'h0000_1003, 32'h0000_1000);
        @(posedge clk);
        #1;
        check("exl.exccode", {27'h0, exccode_o}, {27'h0, 5'h10});
        drive(1'b1, 32'h0000_0100, 1'b1, 8'b0000_0010, 32'h8000_0102, 32'h0000_1003, 32'h0000_1000);
        #1;
        check("exl.kill", {31'h0, mem_kill_o}, 32'h1);
        @(posedge clk);
        #1;
        check("exl.exccode_ades", {27'h0, exccode_o}, {27'h0, 5'h05});
        check("exl.in_delay", {31'h0, in_delay_o}, 32'h1);
        check("exl.exc_pc", exc_pc_o, 32'h0000_0100);
`ifdef EXC_BADVADDR_EN
        check("exl.badvaddr", badvaddr_o, 32'h8000_0102);
`endif
        drive_idle();
        hw_int = 6'h00;
        repeat (3) @(posedge clk);

        // Test 6: asynchronous reset while in SQUASH, then a clean commit after release
        @(negedge clk);
        drive(1'b1, 32'h0000_0300, 1'b1, 8'b0100_0000, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        drive_idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_pc = 32'h0; exp_dly = 1'b0; exp_bv = 32'h0;
        check_regs("arst");
        check("arst.kill", {31'h0, mem_kill_o}, 32'h0);
        check("arst.int_o", {26'h0, int_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h0000_0400, 1'b0, 8'b0000_1000, 32'h0, 32'h0, 32'h0);
        #1;
        check("arst.kill_after", {31'h0, mem_kill_o}, 32'h1);
        @(posedge clk);
        #1;
        check("arst.exccode_after", {27'h0, exccode_o}, {27'h0, 5'h09});
        check("arst.exc_pc_after", exc_pc_o, 32'h0000_0400);
        drive_idle();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
